seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_scan_driver_if.sv | 22 ++
 rtl/seg7_scan_driver.sv | 115 +++++++++++
 tb/tb_seg7_scan_driver.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Display bus for the multiplexed 7-segment scan driver: the value/mask/blanking
// controls in, and the registered cathode, anode and frame-tick lines out.
interface seg7_scan_driver_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   digit_en;
  logic                blank_lz;
  logic [6:0]          seg;
  logic [7:0]          an;
  logic                frame_tick;

  modport master (
    output value, digit_en, blank_lz,
    input  seg, an, frame_tick
  );

  modport slave (
    input  value, digit_en, blank_lz,
    output seg, an, frame_tick
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scanner with per-frame shadow capture, ghost
// blanking at the start of each slot, digit masking and leading-zero blanking.
module seg7_scan_driver #(
  parameter int DIGITS    = 8,
  parameter int DIV       = 100000,
  parameter int GHOST_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_driver_if.slave  bus
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CNT_W-1:0]    cnt_p0;
  logic [IDX_W-1:0]    idx_p0;
  logic [4*DIGITS-1:0] val_sh;
  logic [DIGITS-1:0]   en_sh;
  logic                blz_sh;

  logic [6:0]          seg_p1;
  logic [7:0]          an_p1;
  logic                frame_tick_p1;

  logic                cnt_wrap;
  logic                idx_wrap;
  logic                frame_start;
  logic                ghost;
  logic [DIGITS-1:0]   hi_zero;
  logic [3:0]          nib;
  logic [2:0]          an_sel;
  logic                suppress;
  logic [6:0]          seg_nxt;
  logic [7:0]          an_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Stage p0: scan position and shadow state decode
  always_comb begin
    cnt_wrap    = (cnt_p0 == CNT_W'(DIV - 1));
    idx_wrap    = (idx_p0 == IDX_W'(DIGITS - 1));
    frame_start = (cnt_p0 == '0) && (idx_p0 == '0);
    ghost       = (cnt_p0 < CNT_W'(GHOST_CYC));

    // hi_zero[i]: every shadow nibble from digit i upward is zero
    hi_zero = '0;
    for (int i = 0; i < DIGITS; i++) begin
      hi_zero[i] = ((val_sh >> (4 * i)) == '0);
    end

    nib      = val_sh[4*idx_p0 +: 4];
    an_sel   = 3'(idx_p0);
    suppress = !en_sh[idx_p0] || (blz_sh && (idx_p0 != '0) && hi_zero[idx_p0]);

    an_nxt = 8'hFF;
    if (!ghost && !suppress) begin
      an_nxt[an_sel] = 1'b0;
    end
    seg_nxt = (ghost || suppress) ? 7'h7F : seg_decode(nib);
  end

  // Stage p1: registered display outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_p0        <= '0;
      idx_p0        <= '0;
      val_sh        <= '0;
      en_sh         <= '0;
      blz_sh        <= 1'b0;
      seg_p1        <= 7'h7F;
      an_p1         <= 8'hFF;
      frame_tick_p1 <= 1'b0;
    end else begin
      cnt_p0 <= cnt_wrap ? '0 : cnt_p0 + CNT_W'(1);
      if (cnt_wrap) begin
        idx_p0 <= idx_wrap ? '0 : idx_p0 + IDX_W'(1);
      end
      if (frame_start) begin
        val_sh <= bus.value;
        en_sh  <= bus.digit_en;
        blz_sh <= bus.blank_lz;
      end
      seg_p1        <= seg_nxt;
      an_p1         <= an_nxt;
      frame_tick_p1 <= frame_start;
    end
  end

  assign bus.seg        = seg_p1;
  assign bus.an         = an_p1;
  assign bus.frame_tick = frame_tick_p1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios plus random traffic, checked
// against a frame-position reference model.
module tb_seg7_scan_driver;
  localparam int DIGITS    = 8;
  localparam int DIV       = 4;
  localparam int GHOST_CYC = 1;
  localparam int FRAME     = DIGITS * DIV;

  logic clk = 1'b0;
  logic rst_n;

  seg7_scan_driver_if #(.DIGITS(DIGITS)) bus ();

  seg7_scan_driver #(
    .DIGITS   (DIGITS),
    .DIV      (DIV),
    .GHOST_CYC(GHOST_CYC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // reference model: k = enabled edges since reset release, plus the frame's captured inputs
  int          k;
  logic [31:0] sh_val;
  logic [7:0]  sh_en;
  logic        sh_blz;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int last_tick = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_ft;
    logic [3:0] dig;
    bit         chk_seg;
    bit         off;
    int         p, slot, phase;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      exp_an    = 8'hFF;
      exp_seg   = 7'h7F;
      exp_ft    = 1'b0;
      chk_seg   = 1'b1;
      k         = 0;
      sh_val    = '0;
      sh_en     = '0;
      sh_blz    = 1'b0;
      last_tick = -1;
    end else begin
      p     = k % FRAME;
      slot  = p / DIV;
      phase = p % DIV;
      dig   = 4'((sh_val >> (4 * slot)) & 32'hF);
      off   = (((sh_en >> slot) & 8'd1) == 8'd0) ||
              (sh_blz && (slot > 0) && ((sh_val >> (4 * slot)) == 32'd0));
      exp_ft = (p == 0);
      if (phase < GHOST_CYC) begin
        exp_an  = 8'hFF;
        exp_seg = 7'h7F;
        chk_seg = 1'b0;
      end else if (off) begin
        exp_an  = 8'hFF;
        exp_seg = 7'h7F;
        chk_seg = 1'b1;
      end else begin
        exp_an  = ~(8'd1 << slot);
        exp_seg = seg_tbl[dig];
        chk_seg = 1'b1;
      end
      if (p == 0) begin
        sh_val = bus.value;
        sh_en  = bus.digit_en;
        sh_blz = bus.blank_lz;
      end
      k++;
    end
    @(negedge clk);
    chk("an", 32'(bus.an), 32'(exp_an));
    chk("frame_tick", 32'(bus.frame_tick), 32'(exp_ft));
    if (chk_seg) chk("seg", 32'(bus.seg), 32'(exp_seg));
    if (bus.frame_tick === 1'b1) begin
      if (last_tick >= 0) chk("tick_period", 32'(cyc - last_tick), 32'(FRAME));
      last_tick = cyc;
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.value    = 32'hFFFF_FFFF;
    bus.digit_en = 8'hFF;
    bus.blank_lz = 1'b0;
    repeat (3) step();

    // basic scan
    bus.value = 32'h0000_00A5;
    rst_n     = 1'b1;
    repeat (70) step();

    // leading-zero blanking
    bus.blank_lz = 1'b1;
    repeat (70) step();
    bus.value = 32'h0;
    repeat (70) step();
    bus.blank_lz = 1'b0;

    // mid-frame change must not tear
    bus.value = 32'h1111_1111;
    repeat (40) step();
    for (int i = 0; i < FRAME && (k % FRAME) != 13; i++) step();
    bus.value = 32'h2222_2222;
    repeat (70) step();

    // digit mask
    bus.digit_en = 8'h0F;
    bus.value    = 32'h1234_5678;
    repeat (70) step();
    bus.digit_en = 8'hFF;

    // reset at idx=5, cnt=2
    for (int i = 0; i < FRAME && (k % FRAME) != 22; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (70) step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) bus.value = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 39) == 0) bus.digit_en = 8'($urandom);
      if ($urandom_range(0, 39) == 0) bus.blank_lz = 1'($urandom);
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
